// File: rtl/miss_controller_2way_pkg.sv
// Shared widths, state/op encodings and address helpers for the 2-way miss controller.
// Address layout is {tag, group, offset}; cache address is {way, group}.
package miss_controller_2way_pkg;

    localparam int BW_WORD_ADDR         = 16;
    localparam int BW_BLOCK             = 2;
    localparam int CACHE_BLOCK_CAPACITY = 128;
    localparam int BW_CACHE_ADDR        = $clog2(CACHE_BLOCK_CAPACITY);
    localparam int BW_GRP               = BW_CACHE_ADDR - 1;
    localparam int BW_TAG               = BW_WORD_ADDR - BW_GRP - BW_BLOCK;
    localparam int NUM_GRP              = 1 << BW_GRP;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_EVICT  = 3'd2,
        S_WB     = 3'd3,
        S_FILL   = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_HIT   = 3'd1,
        OP_INVAL = 3'd2,
        OP_CLEAN = 3'd3,
        OP_FILL  = 3'd4
    } repl_op_t;

    function automatic logic [BW_WORD_ADDR-1:0] block_addr(input logic [BW_TAG-1:0] tag,
                                                         input logic [BW_GRP-1:0] grp);
        return {tag, grp, {BW_BLOCK{1'b0}}};
    endfunction

endpackage

// File: rtl/miss_controller_2way_if.sv
// Bundle of core, tag-memory, block-transfer and counter signals of the miss controller.
// master = controller side, slave = environment side.
interface miss_controller_2way_if;
    import miss_controller_2way_pkg::*;

    logic                     req_i;
    logic                     rw_i;
    logic [BW_WORD_ADDR-1:0]  addr_i;
    logic                     ready_o;
    logic                     done_o;
    logic                     hit_o;
    logic [BW_CACHE_ADDR-1:0] cache_addr_o;
    logic [BW_TAG-1:0]        tm_tag_o;
    logic [BW_GRP-1:0]        tm_group_o;
    logic [BW_CACHE_ADDR-1:0] tm_addr_o;
    logic                     tm_wren_o;
    logic                     tm_rmen_o;
    logic                     tm_hit_i;
    logic [BW_CACHE_ADDR-1:0] tm_addr_i;
    logic [BW_TAG-1:0]        tm_tag_i;
    logic                     mem_req_o;
    logic                     mem_rw_o;
    logic [BW_WORD_ADDR-1:0]  mem_addr_o;
    logic                     mem_done_i;
    logic [31:0]              hit_count_o;
    logic [31:0]              miss_count_o;
    logic [31:0]              wb_count_o;

    modport master (
        input  req_i, rw_i, addr_i, tm_hit_i, tm_addr_i, tm_tag_i, mem_done_i,
        output ready_o, done_o, hit_o, cache_addr_o, tm_tag_o, tm_group_o, tm_addr_o,
               tm_wren_o, tm_rmen_o, mem_req_o, mem_rw_o, mem_addr_o,
               hit_count_o, miss_count_o, wb_count_o
    );

    modport slave (
        output req_i, rw_i, addr_i, tm_hit_i, tm_addr_i, tm_tag_i, mem_done_i,
        input  ready_o, done_o, hit_o, cache_addr_o, tm_tag_o, tm_group_o, tm_addr_o,
               tm_wren_o, tm_rmen_o, mem_req_o, mem_rw_o, mem_addr_o,
               hit_count_o, miss_count_o, wb_count_o
    );

endinterface

// File: rtl/miss_controller_2way_replacement_state.sv
// Per-group valid/dirty/LRU bookkeeping and victim choice (invalid way first, else LRU).
module replacement_state_2way
    import miss_controller_2way_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [BW_GRP-1:0] grp,
    input  logic              way,
    input  repl_op_t          op,
    input  logic              rw,
    output logic              victim,
    output logic              victim_valid,
    output logic              way_dirty
);

    logic [1:0][NUM_GRP-1:0] valid_r;
    logic [1:0][NUM_GRP-1:0] dirty_r;
    logic [NUM_GRP-1:0]      lru_r;

    // victim selection and dirty lookup for the addressed way
    always_comb begin
        victim = 1'b0;
        if (!valid_r[0][grp]) begin
            victim = 1'b0;
        end else if (!valid_r[1][grp]) begin
            victim = 1'b1;
        end else begin
            victim = lru_r[grp];
        end
        victim_valid = valid_r[victim][grp];
        way_dirty    = dirty_r[way][grp];
    end

    // state array updates driven by the controller op
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_r <= '0;
            dirty_r <= '0;
            lru_r   <= '0;
        end else begin
            case (op)
                OP_HIT: begin
                    lru_r[grp]        <= ~way;
                    dirty_r[way][grp] <= dirty_r[way][grp] | rw;
                end
                OP_INVAL: valid_r[way][grp] <= 1'b0;
                OP_CLEAN: dirty_r[way][grp] <= 1'b0;
                OP_FILL: begin
                    valid_r[way][grp] <= 1'b1;
                    dirty_r[way][grp] <= rw;
                    lru_r[grp]        <= ~way;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/miss_controller_2way.sv
// Request sequencer for the 2-way tag path: lookup, victim eviction/writeback, fill and tag commit.
module miss_controller_2way
    import miss_controller_2way_pkg::*;
(
    input  logic                   clock_i,
    input  logic                   resetn_i,
    miss_controller_2way_if.master bus
);

    state_t            state_r, state_s;
    logic [BW_TAG-1:0] req_tag_r, victim_tag_r;
    logic [BW_GRP-1:0] req_grp_r;
    logic              req_rw_r, way_r, hit_r;
    logic [31:0]       hit_count_r, miss_count_r, wb_count_r;
    repl_op_t          op_s;
    logic              sel_way_s, victim_s, victim_valid_s, way_dirty_s;

    replacement_state_2way u_repl (
        .clk          (clock_i),
        .resetn       (resetn_i),
        .grp          (req_grp_r),
        .way          (sel_way_s),
        .op           (op_s),
        .rw           (req_rw_r),
        .victim       (victim_s),
        .victim_valid (victim_valid_s),
        .way_dirty    (way_dirty_s)
    );

    // next state, replacement op and state-decoded outputs
    always_comb begin
        state_s          = state_r;
        op_s             = OP_NONE;
        sel_way_s        = way_r;
        bus.ready_o      = 1'b0;
        bus.done_o       = 1'b0;
        bus.hit_o        = 1'b0;
        bus.cache_addr_o = '0;
        bus.tm_tag_o     = '0;
        bus.tm_group_o   = '0;
        bus.tm_addr_o    = '0;
        bus.tm_wren_o    = 1'b0;
        bus.tm_rmen_o    = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_rw_o     = 1'b0;
        bus.mem_addr_o   = '0;
        case (state_r)
            S_IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.req_i) state_s = S_LOOKUP;
                else           state_s = S_IDLE;
            end
            S_LOOKUP: begin
                bus.tm_tag_o   = req_tag_r;
                bus.tm_group_o = req_grp_r;
                if (bus.tm_hit_i) begin
                    op_s      = OP_HIT;
                    sel_way_s = bus.tm_addr_i[BW_CACHE_ADDR-1];
                    state_s   = S_DONE;
                end else if (victim_valid_s) begin
                    state_s = S_EVICT;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_EVICT: begin
                bus.tm_addr_o = {way_r, req_grp_r};
                bus.tm_rmen_o = 1'b1;
                op_s          = OP_INVAL;
                if (way_dirty_s) state_s = S_WB;
                else             state_s = S_FILL;
            end
            S_WB: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_rw_o   = 1'b1;
                bus.mem_addr_o = block_addr(victim_tag_r, req_grp_r);
                if (bus.mem_done_i) begin
                    op_s    = OP_CLEAN;
                    state_s = S_FILL;
                end else begin
                    state_s = S_WB;
                end
            end
            S_FILL: begin
                bus.mem_req_o  = 1'b1;
                bus.mem_addr_o = block_addr(req_tag_r, req_grp_r);
                if (bus.mem_done_i) state_s = S_UPDATE;
                else                state_s = S_FILL;
            end
            S_UPDATE: begin
                bus.tm_addr_o = {way_r, req_grp_r};
                bus.tm_tag_o  = req_tag_r;
                bus.tm_wren_o = 1'b1;
                op_s          = OP_FILL;
                state_s       = S_DONE;
            end
            S_DONE: begin
                bus.done_o       = 1'b1;
                bus.hit_o        = hit_r;
                bus.cache_addr_o = {way_r, req_grp_r};
                state_s          = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // state register, request latch, way/victim tag capture and event counters
    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_r      <= S_IDLE;
            req_tag_r    <= '0;
            req_grp_r    <= '0;
            req_rw_r     <= 1'b0;
            way_r        <= 1'b0;
            hit_r        <= 1'b0;
            victim_tag_r <= '0;
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
            wb_count_r   <= 32'd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (bus.req_i) begin
                        req_tag_r <= bus.addr_i[BW_WORD_ADDR-1 -: BW_TAG];
                        req_grp_r <= bus.addr_i[BW_BLOCK +: BW_GRP];
                        req_rw_r  <= bus.rw_i;
                    end
                end
                S_LOOKUP: begin
                    hit_r <= bus.tm_hit_i;
                    if (bus.tm_hit_i) begin
                        way_r       <= bus.tm_addr_i[BW_CACHE_ADDR-1];
                        hit_count_r <= hit_count_r + 32'd1;
                    end else begin
                        way_r        <= victim_s;
                        miss_count_r <= miss_count_r + 32'd1;
                    end
                end
                S_EVICT: victim_tag_r <= bus.tm_tag_i;
                S_WB: begin
                    if (bus.mem_done_i) wb_count_r <= wb_count_r + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.hit_count_o  = hit_count_r;
    assign bus.miss_count_o = miss_count_r;
    assign bus.wb_count_o   = wb_count_r;

endmodule

// File: tb/tb_miss_controller_2way.sv
// Directed bench for miss_controller_2way: behavioural tag memory, memory responder and
// a completion scoreboard checked whenever done_o is seen.
module tb_miss_controller_2way;
    import miss_controller_2way_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    miss_controller_2way_if bus();

    miss_controller_2way dut (
        .clock_i  (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       hit;
        logic [6:0] caddr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic              tmv[2][NUM_GRP];
    logic [BW_TAG-1:0] tmt[2][NUM_GRP];

    task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    // behavioural tag memory: combinational lookup and read
    always_comb begin
        bus.tm_hit_i  = 1'b0;
        bus.tm_addr_i = '0;
        for (int w = 0; w < 2; w++) begin
            if (tmv[w][bus.tm_group_o] && tmt[w][bus.tm_group_o] == bus.tm_tag_o) begin
                bus.tm_hit_i  = 1'b1;
                bus.tm_addr_i = {1'(w), bus.tm_group_o};
            end
        end
        bus.tm_tag_i = tmt[bus.tm_addr_o[6]][bus.tm_addr_o[5:0]];
    end

    // tag memory write / invalidate, cleared alongside the controller
    always @(posedge clk) begin
        if (!resetn) begin
            for (int w = 0; w < 2; w++)
                for (int g = 0; g < NUM_GRP; g++) begin
                    tmv[w][g] <= 1'b0;
                    tmt[w][g] <= '0;
                end
        end else if (bus.tm_wren_o) begin
            tmv[bus.tm_addr_o[6]][bus.tm_addr_o[5:0]] <= 1'b1;
            tmt[bus.tm_addr_o[6]][bus.tm_addr_o[5:0]] <= bus.tm_tag_o;
        end else if (bus.tm_rmen_o) begin
            tmv[bus.tm_addr_o[6]][bus.tm_addr_o[5:0]] <= 1'b0;
        end
    end

    // completion monitor: pop scoreboard on each done_o
    always @(negedge clk) begin
        if (resetn && bus.done_o) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("done_hit", 32'(bus.hit_o), 32'(mon_e.hit));
                check("cache_addr", 32'(bus.cache_addr_o), 32'(mon_e.caddr));
            end
        end
    end

    function automatic logic [15:0] mk_addr(input logic [7:0] tag, input logic [5:0] grp);
        return {tag, grp, 2'b01};
    endfunction

    task automatic do_req(input logic rw, input logic [7:0] tag, input logic [5:0] grp,
                          input logic exp_hit, input logic exp_way);
        int n = 0;
        while (!bus.ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", 32'(bus.ready_o), 32'd1);
        bus.req_i  = 1'b1;
        bus.rw_i   = rw;
        bus.addr_i = mk_addr(tag, grp);
        sb.push_back({exp_hit, exp_way, grp});
        @(negedge clk);
        bus.req_i = 1'b0;
        check("ready_low_after_accept", 32'(bus.ready_o), 32'd0);
    endtask

    task automatic wait_mem(input string nm, input logic exp_rw, input logic [15:0] exp_addr);
        int n = 0;
        while (!bus.mem_req_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_req"}, 32'(bus.mem_req_o), 32'd1);
        check({nm, "_rw"}, 32'(bus.mem_rw_o), 32'(exp_rw));
        check({nm, "_addr"}, 32'(bus.mem_addr_o), 32'(exp_addr));
    endtask

    task automatic pulse_mem(input string nm, input logic exp_req_after);
        bus.mem_done_i = 1'b1;
        @(negedge clk);
        bus.mem_done_i = 1'b0;
        check({nm, "_req_after_done"}, 32'(bus.mem_req_o), 32'(exp_req_after));
    endtask

    task automatic wait_done(input string nm, input int exp_lat);
        int n = 0;
        while (!bus.done_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_counts(input string nm, input int h, input int m, input int w);
        check({nm, "_hits"}, bus.hit_count_o, 32'(h));
        check({nm, "_misses"}, bus.miss_count_o, 32'(m));
        check({nm, "_wbs"}, bus.wb_count_o, 32'(w));
    endtask

    initial begin
        int held;
        bus.req_i      = 1'b0;
        bus.rw_i       = 1'b0;
        bus.addr_i     = '0;
        bus.mem_done_i = 1'b0;
        resetn         = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        check("rst_ready", 32'(bus.ready_o), 32'd1);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_tm_wren", 32'(bus.tm_wren_o), 32'd0);
        check("rst_cache_addr", 32'(bus.cache_addr_o), 32'd0);
        check_counts("rst", 0, 0, 0);

        // cold read of tag 5, group 3: invalid miss into way0
        do_req(1'b0, 8'h05, 6'd3, 1'b0, 1'b0);
        wait_mem("fill5", 1'b0, block_addr(8'h05, 6'd3));
        pulse_mem("fill5", 1'b0);
        check("upd_wren", 32'(bus.tm_wren_o), 32'd1);
        check("upd_rmen", 32'(bus.tm_rmen_o), 32'd0);
        check("upd_addr", 32'(bus.tm_addr_o), 32'h03);
        check("upd_tag", 32'(bus.tm_tag_o), 32'h05);
        wait_done("fill5", 1);

        do_req(1'b0, 8'h05, 6'd3, 1'b1, 1'b0);
        wait_done("hit5", 1);

        // second tag fills way1, then touch way0 so way1 is LRU
        do_req(1'b0, 8'h06, 6'd3, 1'b0, 1'b1);
        wait_mem("fill6", 1'b0, block_addr(8'h06, 6'd3));
        pulse_mem("fill6", 1'b0);
        wait_done("fill6", 1);
        do_req(1'b0, 8'h05, 6'd3, 1'b1, 1'b0);
        wait_done("hit5b", 1);

        // clean eviction of way1, no writeback
        do_req(1'b0, 8'h07, 6'd3, 1'b0, 1'b1);
        @(negedge clk);
        check("evict_rmen", 32'(bus.tm_rmen_o), 32'd1);
        check("evict_wren", 32'(bus.tm_wren_o), 32'd0);
        check("evict_addr", 32'(bus.tm_addr_o), 32'h43);
        wait_mem("fill7", 1'b0, block_addr(8'h07, 6'd3));
        pulse_mem("fill7", 1'b0);
        wait_done("fill7", 1);

        // write-hit way0, touch way1, then evict dirty way0 with a slow fill
        do_req(1'b1, 8'h05, 6'd3, 1'b1, 1'b0);
        wait_done("whit5", 1);
        do_req(1'b0, 8'h07, 6'd3, 1'b1, 1'b1);
        wait_done("hit7", 1);
        do_req(1'b0, 8'h08, 6'd3, 1'b0, 1'b0);
        wait_mem("wb5", 1'b1, block_addr(8'h05, 6'd3));
        pulse_mem("wb5", 1'b1);
        wait_mem("fill8", 1'b0, block_addr(8'h08, 6'd3));
        held = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_req_o && !bus.ready_o) held++;
        end
        check("fill_hold_cycles", 32'(held), 32'd20);
        pulse_mem("fill8", 1'b0);
        wait_done("fill8", 1);
        check_counts("mid", 4, 4, 1);

        // get a dirty LRU victim in way1, then reset in the middle of its writeback
        do_req(1'b1, 8'h07, 6'd3, 1'b1, 1'b1);
        wait_done("whit7", 1);
        do_req(1'b0, 8'h08, 6'd3, 1'b1, 1'b0);
        wait_done("hit8", 1);
        do_req(1'b0, 8'h09, 6'd3, 1'b0, 1'b1);
        wait_mem("wb7", 1'b1, block_addr(8'h07, 6'd3));
        resetn = 1'b0;
        sb.delete();
        @(negedge clk);
        resetn = 1'b1;
        check("wbrst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("wbrst_ready", 32'(bus.ready_o), 32'd1);
        check_counts("wbrst", 0, 0, 0);
        bus.mem_done_i = 1'b1;
        @(negedge clk);
        bus.mem_done_i = 1'b0;
        @(negedge clk);
        check("stray_done_ready", 32'(bus.ready_o), 32'd1);
        check("stray_done_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("stray_done_done", 32'(bus.done_o), 32'd0);
        check_counts("stray", 0, 0, 0);

        // top group, max tag: counters restart from zero
        do_req(1'b1, 8'hFF, 6'd63, 1'b0, 1'b0);
        wait_mem("fillff", 1'b0, block_addr(8'hFF, 6'd63));
        pulse_mem("fillff", 1'b0);
        wait_done("fillff", 1);
        do_req(1'b0, 8'hFF, 6'd63, 1'b1, 1'b0);
        wait_done("hitff1", 1);
        do_req(1'b0, 8'hFF, 6'd63, 1'b1, 1'b0);
        wait_done("hitff2", 1);
        do_req(1'b1, 8'hFF, 6'd63, 1'b1, 1'b0);
        wait_done("hitff3", 1);
        @(negedge clk);
        check_counts("final", 3, 1, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
